pump_pwm_driver: RTL

PUMP_PWM_DRIVER -- requirements
Module: pump_pwm_driver

---
 rtl/pump_pwm_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pump_pwm_driver.sv
// Two-channel pump gate PWM driver with slew-limited duty ramping and emergency stop.
// Duty targets are sampled once per PWM period so every period is a whole, glitch-free period.
module pump_pwm_driver #(
   parameter int PRESCALE  = 8,
   parameter int RAMP_STEP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pwm_duty_a,
   input  logic [7:0] pwm_duty_b,
   input  logic       estop,
   output logic       pwm_a,
   output logic       pwm_b,
   output logic [7:0] duty_eff_a,
   output logic [7:0] duty_eff_b,
   output logic       at_target_a,
   output logic       at_target_b
);

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2,
      STEADY    = 2'd3
   } pump_state_t;

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
   localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

   logic [PW-1:0] presc;
   logic [7:0]    cnt;
   logic          tick;
   logic          boundary;

   pump_state_t state_a, state_a_next;
   pump_state_t state_b, state_b_next;
   logic [7:0]  tgt_a, tgt_a_next, eff_a_next;
   logic [7:0]  tgt_b, tgt_b_next, eff_b_next;
   logic        at_target_a_next, at_target_b_next;

   // Move eff toward tgt by at most one step; 9-bit math keeps it inside 0..255.
   function automatic logic [7:0] ramp_toward(input logic [7:0] eff, input logic [7:0] tgt);
      logic [8:0] e9;
      logic [8:0] t9;
      logic [8:0] r;
      e9 = {1'b0, eff};
      t9 = {1'b0, tgt};
      if (t9 >= e9) begin
         r = ((t9 - e9) <= STEP9) ? t9 : (e9 + STEP9);
      end else begin
         r = ((e9 - t9) <= STEP9) ? t9 : (e9 - STEP9);
      end
      return r[7:0];
   endfunction

   function automatic pump_state_t classify(input logic [7:0] eff, input logic [7:0] tgt);
      pump_state_t s;
      if (eff == 8'd0 && tgt == 8'd0) begin
         s = OFF;
      end else if (eff == tgt) begin
         s = STEADY;
      end else if (eff < tgt) begin
         s = RAMP_UP;
      end else begin
         s = RAMP_DOWN;
      end
      return s;
   endfunction

   assign tick     = (presc == PRESCALE_LAST);
   assign boundary = tick && (cnt == 8'd255);

   // Prescaler and shared PWM counter free-run, even during estop.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         cnt   <= 8'd0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   always_comb begin
      state_a_next     = state_a;
      eff_a_next       = duty_eff_a;
      tgt_a_next       = tgt_a;
      at_target_a_next = at_target_a;
      if (boundary) begin
         tgt_a_next   = pwm_duty_a;
         eff_a_next   = ramp_toward(duty_eff_a, pwm_duty_a);
         state_a_next = classify(eff_a_next, pwm_duty_a);
      end
      if (estop) begin
         eff_a_next   = 8'd0;
         state_a_next = OFF;
      end
      if (boundary || estop) begin
         at_target_a_next = (eff_a_next == tgt_a_next);
      end
   end

   always_comb begin
      state_b_next     = state_b;
      eff_b_next       = duty_eff_b;
      tgt_b_next       = tgt_b;
      at_target_b_next = at_target_b;
      if (boundary) begin
         tgt_b_next   = pwm_duty_b;
         eff_b_next   = ramp_toward(duty_eff_b, pwm_duty_b);
         state_b_next = classify(eff_b_next, pwm_duty_b);
      end
      if (estop) begin
         eff_b_next   = 8'd0;
         state_b_next = OFF;
      end
      if (boundary || estop) begin
         at_target_b_next = (eff_b_next == tgt_b_next);
      end
   end

   // New eff lands on the same edge the counter wraps to 0, so it rules whole periods.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_a     <= OFF;
         state_b     <= OFF;
         duty_eff_a  <= 8'd0;
         duty_eff_b  <= 8'd0;
         tgt_a       <= 8'd0;
         tgt_b       <= 8'd0;
         at_target_a <= 1'b0;
         at_target_b <= 1'b0;
         pwm_a       <= 1'b0;
         pwm_b       <= 1'b0;
      end else begin
         state_a     <= state_a_next;
         state_b     <= state_b_next;
         duty_eff_a  <= eff_a_next;
         duty_eff_b  <= eff_b_next;
         tgt_a       <= tgt_a_next;
         tgt_b       <= tgt_b_next;
         at_target_a <= at_target_a_next;
         at_target_b <= at_target_b_next;
         pwm_a       <= (cnt < duty_eff_a) && !estop;
         pwm_b       <= (cnt < duty_eff_b) && !estop;
      end
   end

endmodule
